// File: rtl/addsub_seq_ctrl_if.sv
// Handshake/result bundle for addsub_seq_ctrl.
//   master: drives start, A, B, sub; observes busy, done, Sum, Cout, Ovfl, nib_idx
//   slave : the controller side of the same signals
interface addsub_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned NIBS = WIDTH / 4;
  localparam int unsigned NIW  = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovfl;
  logic [NIW-1:0]   nib_idx;

  modport master (
    output start, A, B, sub,
    input  busy, done, Sum, Cout, Ovfl, nib_idx
  );

  modport slave (
    input  start, A, B, sub,
    output busy, done, Sum, Cout, Ovfl, nib_idx
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller. One 4-bit slice is reused
// for WIDTH/4 cycles, LSB nibble first, with the carry held in a register.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of addsub_seq_ctrl_if (start/A/B/sub in,
//           busy/done/Sum/Cout/Ovfl/nib_idx out, all outputs registered)
module addsub_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  addsub_seq_ctrl_if.slave  bus
);
  localparam int unsigned NIBS = WIDTH / 4;
  localparam int unsigned NIW  = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovfl_q, ovfl_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [NIW-1:0]   idx_q, idx_d;

  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;
  logic             c_msb;
  logic             accept;

  // Shared 4-bit slice; B is inverted for subtract, the +1 comes from carry_q.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBS); i++) begin
      if (idx_q == NIW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4] ^ {4{sub_q}};
      end
    end
    nib_sum = 5'(a_nib) + 5'(b_nib) + 5'(carry_q);
    // Carry into the nibble's top bit, recovered from its sum bit.
    c_msb   = a_nib[3] ^ b_nib[3] ^ nib_sum[3];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: accept = bus.start;
      RUN: begin
        for (int i = 0; i < int'(NIBS); i++) begin
          if (idx_q == NIW'(i)) sum_d[4*i +: 4] = nib_sum[3:0];
        end
        carry_d = nib_sum[4];
        idx_d   = idx_q + NIW'(1);
        if (idx_q == NIW'(NIBS - 1)) begin
          cout_d  = nib_sum[4];
          ovfl_d  = c_msb ^ nib_sum[4];
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: accept = bus.start;
      default: state_d = IDLE;
    endcase

    // New operation accepted from IDLE or DONE; operands isolated from here on.
    if (accept) begin
      state_d = RUN;
      a_d     = bus.A;
      b_d     = bus.B;
      sub_d   = bus.sub;
      carry_d = bus.sub;
      idx_d   = '0;
      busy_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Sum     = sum_q;
  assign bus.Cout    = cout_q;
  assign bus.Ovfl    = ovfl_q;
  assign bus.nib_idx = idx_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
module tb_addsub_seq_ctrl;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  addsub_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  addsub_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a one-cycle start pulse; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Advance until done is seen or the budget expires; cyc counts edges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) break;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.Cout, bus.Ovfl} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got busy/done/cout/ovfl=%b expected 0000",
               {bus.busy, bus.done, bus.Cout, bus.Ovfl});
    end
    total++;
    if (bus.Sum !== 16'h0000 || bus.nib_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_sum_idx: got Sum=%h nib_idx=%0d expected 0000/0", bus.Sum, bus.nib_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    start_op(16'h1234, 16'h0FFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.nib_idx !== 2'(k)) begin
        bad++;
        $display("FAIL add_run_cycle%0d: got busy=%b done=%b nib_idx=%0d expected 1/0/%0d",
                 k, bus.busy, bus.done, bus.nib_idx, k);
      end
      @(posedge clk); #1;
    end
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL add_done_latency: got done=%b busy=%b expected 1/0", bus.done, bus.busy);
    end
    total++;
    if ({bus.Sum, bus.Cout, bus.Ovfl} !== {16'h2233, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_result: got Sum=%h Cout=%b Ovfl=%b expected 2233/0/0",
               bus.Sum, bus.Cout, bus.Ovfl);
    end
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0 || bus.Sum !== 16'h2233) begin
      bad++;
      $display("FAIL add_done_pulse_hold: got done=%b Sum=%h expected 0/2233", bus.done, bus.Sum);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] va [2] = '{16'h7FFF, 16'hFFFF};
    logic [15:0] vb [2] = '{16'h0001, 16'h0001};
    logic [17:0] ve [2] = '{{16'h8000, 1'b0, 1'b1}, {16'h0000, 1'b1, 1'b0}};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i], 1'b0);
      wait_done(cyc);
      total++;
      if (cyc !== 4 || {bus.Sum, bus.Cout, bus.Ovfl} !== ve[i]) begin
        bad++;
        $display("FAIL overflow_%0d: got cyc=%0d Sum=%h Cout=%b Ovfl=%b expected cyc=4 {Sum,Cout,Ovfl}=%h",
                 i, cyc, bus.Sum, bus.Cout, bus.Ovfl, ve[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sub();
    logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'h0000};
    logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h8000};
    logic [17:0] ve [3] = '{{16'hFFFE, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1}, {16'h8000, 1'b0, 1'b1}};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b1);
      wait_done(cyc);
      total++;
      if (cyc !== 4 || {bus.Sum, bus.Cout, bus.Ovfl} !== ve[i]) begin
        bad++;
        $display("FAIL sub_%0d: got cyc=%0d Sum=%h Cout=%b Ovfl=%b expected cyc=4 {Sum,Cout,Ovfl}=%h",
                 i, cyc, bus.Sum, bus.Cout, bus.Ovfl, ve[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Start re-pulsed mid-run with new operands, and operands changed afterwards.
  task automatic test_ignore_start();
    int cyc;
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    bus.A = 16'h5555; bus.B = 16'h0001; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = 16'hFFFF; bus.B = 16'hFFFF;
    wait_done(cyc);
    total++;
    if (cyc !== 2 || {bus.Sum, bus.Cout, bus.Ovfl} !== {16'h3333, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ignore_start: got cyc=%0d Sum=%h Cout=%b Ovfl=%b expected 2/3333/0/0",
               cyc, bus.Sum, bus.Cout, bus.Ovfl);
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_no_queue: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(16'h00F0, 16'h0F0F, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc !== 4 || bus.Sum !== 16'h0FFF) begin
      bad++;
      $display("FAIL b2b_first: got cyc=%0d Sum=%h expected 4/0fff", cyc, bus.Sum);
    end
    start_op(16'h0001, 16'h0001, 1'b0);
    total++;
    if (bus.busy !== 1'b1 || bus.nib_idx !== 2'd0) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b nib_idx=%0d expected 1/0", bus.busy, bus.nib_idx);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 4 || {bus.Sum, bus.Cout, bus.Ovfl} !== {16'h0002, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second: got cyc=%0d Sum=%h Cout=%b Ovfl=%b expected 4/0002/0/0",
               cyc, bus.Sum, bus.Cout, bus.Ovfl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int pulses;
    start_op(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (bus.nib_idx !== 2'd2 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got nib_idx=%0d busy=%b expected 2/1", bus.nib_idx, bus.busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({bus.busy, bus.done, bus.Cout, bus.Ovfl} !== 4'b0000 || bus.Sum !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_clear: got busy/done/cout/ovfl=%b Sum=%h expected 0000/0000",
               {bus.busy, bus.done, bus.Cout, bus.Ovfl}, bus.Sum);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL midrst_aborted: got %0d active cycles expected 0", pulses);
    end
    start_op(16'h0123, 16'h0456, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc !== 4 || {bus.Sum, bus.Cout, bus.Ovfl} !== {16'h0579, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_after: got cyc=%0d Sum=%h Cout=%b Ovfl=%b expected 4/0579/0/0",
               cyc, bus.Sum, bus.Cout, bus.Ovfl);
    end
    @(posedge clk); #1;
  endtask

  // Random operands and gaps (gap 0 issues the next op in the DONE cycle).
  task automatic test_random();
    logic [15:0] a, b, bx, s;
    logic        op, c, v;
    logic [16:0] full;
    int          cyc;
    int          gap;
    for (int n = 0; n < 1000; n++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 1'($urandom);
      bx = op ? ~b : b;
      full = 17'(a) + 17'(bx) + 17'(op);
      s  = full[15:0];
      c  = full[16];
      v  = op ? ((a[15] != b[15]) && (s[15] != a[15]))
              : ((a[15] == b[15]) && (s[15] != a[15]));
      start_op(a, b, op);
      wait_done(cyc);
      total++;
      if (cyc !== 4 || bus.busy !== 1'b0 || {bus.Sum, bus.Cout, bus.Ovfl} !== {s, c, v}) begin
        bad++;
        $display("FAIL rand_%0d: A=%h B=%h sub=%b got cyc=%0d busy=%b Sum=%h Cout=%b Ovfl=%b expected 4/0/%h/%b/%b",
                 n, a, b, op, cyc, bus.busy, bus.Sum, bus.Cout, bus.Ovfl, s, c, v);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Sum !== s) begin
          bad++;
          $display("FAIL rand_idle_%0d: got done=%b busy=%b Sum=%h expected 0/0/%h",
                   n, bus.done, bus.busy, bus.Sum, s);
        end
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sub   = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
